// File: rtl/param_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : param_mod_counter_if
// Description : Control/status bundle for param_mod_counter. The master side
//               drives enable, direction, clear, load and capture requests;
//               the slave side (the counter) returns count, terminal-count,
//               overflow and snapshot values.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_mod_counter_if #(
  parameter int W = 16
) ();

  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [W-1:0] din;
  logic         ovf_clr;
  logic         cap;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;
  logic [W-1:0] cap_q;
  logic         cap_vld;

  modport master (
    output en, up, clr, load, din, ovf_clr, cap,
    input  q, tc, ovf, cap_q, cap_vld
  );

  modport slave (
    input  en, up, clr, load, din, ovf_clr, cap,
    output q, tc, ovf, cap_q, cap_vld
  );

endinterface
`default_nettype wire

// File: rtl/param_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_mod_counter
// Description : Modulo-MOD up/down counter with a divide-by-DIV enable
//               prescaler, synchronous clear and saturating load, one-cycle
//               terminal-count pulse and sticky overflow flag.
//               Optional snapshot register compiled in when the macro
//               PARAM_MOD_COUNTER_CAPTURE_EN is defined; otherwise cap is
//               ignored and cap_q / cap_vld are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module param_mod_counter #(
  parameter int MOD = 65536,
  parameter int DIV = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_,
  param_mod_counter_if.slave    bus
);

  localparam int           W     = $clog2(MOD);
  localparam int           PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] C_MAX = W'(MOD - 1);

  logic         w_step;
  logic         w_wrap;
  logic [W-1:0] w_load_val;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;
  logic         tc_q;
  logic         ovf_d;
  logic         ovf_q;

  // --------------------------------------------------------------------------
  // Prescaler: one step every DIV enabled cycles; clear and load restart it.
  // --------------------------------------------------------------------------
  generate
    if (DIV == 1) begin : g_nodiv
      assign w_step = bus.en;
    end else begin : g_div
      localparam logic [PW-1:0] C_PRE_MAX = PW'(DIV - 1);
      logic [PW-1:0] pre_q;

      // Prescale phase counter, holds while en is low
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          pre_q <= '0;
        end else if (bus.clr || bus.load) begin
          pre_q <= '0;
        end else if (bus.en) begin
          pre_q <= (pre_q == C_PRE_MAX) ? '0 : pre_q + PW'(1);
        end
      end

      assign w_step = bus.en && (pre_q == C_PRE_MAX);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Load value saturates to MOD-1; unnecessary when MOD fills the W-bit range.
  // --------------------------------------------------------------------------
  generate
    if (MOD == (2 ** W)) begin : g_nosat
      assign w_load_val = bus.din;
    end else begin : g_sat
      assign w_load_val = (bus.din > C_MAX) ? C_MAX : bus.din;
    end
  endgenerate

  // Next count and wrap detect; wrap compares against MOD-1 explicitly so
  // non-power-of-two moduli behave identically to power-of-two ones.
  always_comb begin
    cnt_d  = cnt_q;
    w_wrap = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = w_load_val;
    end else if (w_step) begin
      if (bus.up) begin
        if (cnt_q == C_MAX) begin
          cnt_d  = '0;
          w_wrap = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = C_MAX;
          w_wrap = 1'b1;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
    end
    // A wrap in the same cycle as ovf_clr keeps the flag set
    ovf_d = w_wrap ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  // Count, terminal-count pulse and sticky overflow registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= w_wrap;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

`ifdef PARAM_MOD_COUNTER_CAPTURE_EN
  logic [W-1:0] snap_q;
  logic         snap_vld_q;

  // Snapshot of the pre-update count, independent of clear/load/step
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      snap_vld_q <= bus.cap;
      if (bus.cap) begin
        snap_q <= cnt_q;
      end
    end
  end

  assign bus.cap_q   = snap_q;
  assign bus.cap_vld = snap_vld_q;
`else
  assign bus.cap_q   = '0;
  assign bus.cap_vld = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_mod_counter
// Description : Self-checking bench for param_mod_counter. Four instances
//               (MOD/DIV = 10/1, 10/3, 65536/1, 2/1) are checked every cycle
//               against an arithmetic model, plus hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_mod_counter;

  logic clk;
  logic rst_;
  logic chk_en;
  int   compared;
  int   mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_mod_counter_if #(.W(4))  ifa ();
  param_mod_counter_if #(.W(4))  ifb ();
  param_mod_counter_if #(.W(16)) ifc ();
  param_mod_counter_if #(.W(1))  ifd ();

  param_mod_counter #(.MOD(10),    .DIV(1)) u_a (.clk(clk), .rst_(rst_), .bus(ifa));
  param_mod_counter #(.MOD(10),    .DIV(3)) u_b (.clk(clk), .rst_(rst_), .bus(ifb));
  param_mod_counter #(.MOD(65536), .DIV(1)) u_c (.clk(clk), .rst_(rst_), .bus(ifc));
  param_mod_counter #(.MOD(2),     .DIV(1)) u_d (.clk(clk), .rst_(rst_), .bus(ifd));

  // Model state: what each counter must show after an edge
  typedef struct {
    int q;
    int pre;
    bit tc;
    bit ovf;
    int capq;
    bit capvld;
  } mstate_t;

  mstate_t m [4];

  function automatic mstate_t mreset();
    mstate_t r;
    r.q = 0; r.pre = 0; r.tc = 0; r.ovf = 0; r.capq = 0; r.capvld = 0;
    return r;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int mod, int div, bit en, bit up,
                                    bit clr, bit load, int din, bit ovf_clr, bit cap);
    mstate_t n = s;
    bit wrap = 1'b0;
    n.tc = 1'b0;
`ifdef PARAM_MOD_COUNTER_CAPTURE_EN
    n.capvld = cap;
    if (cap) n.capq = s.q;
`endif
    if (clr) begin
      n.q = 0; n.pre = 0;
    end else if (load) begin
      n.q = (din > mod - 1) ? mod - 1 : din;
      n.pre = 0;
    end else if (en) begin
      if (s.pre == div - 1) begin
        n.pre = 0;
        if (up) begin
          n.q  = (s.q + 1) % mod;
          wrap = (s.q == mod - 1);
        end else begin
          n.q  = (s.q + mod - 1) % mod;
          wrap = (s.q == 0);
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    n.tc = wrap;
    if (wrap) n.ovf = 1'b1;
    else if (ovf_clr) n.ovf = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 4; i++) m[i] = mreset();
    end else begin
      m[0] = mstep(m[0], 10, 1, ifa.en, ifa.up, ifa.clr, ifa.load, int'(ifa.din), ifa.ovf_clr, ifa.cap);
      m[1] = mstep(m[1], 10, 3, ifb.en, ifb.up, ifb.clr, ifb.load, int'(ifb.din), ifb.ovf_clr, ifb.cap);
      m[2] = mstep(m[2], 65536, 1, ifc.en, ifc.up, ifc.clr, ifc.load, int'(ifc.din), ifc.ovf_clr, ifc.cap);
      m[3] = mstep(m[3], 2, 1, ifd.en, ifd.up, ifd.clr, ifd.load, int'(ifd.din), ifd.ovf_clr, ifd.cap);
    end
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk(string nm, mstate_t e, logic [31:0] q, logic tc, logic ovf,
                     logic [31:0] capq, logic capvld);
    cmp({nm, ".q"},       q,             32'(e.q));
    cmp({nm, ".tc"},      {31'd0, tc},     {31'd0, e.tc});
    cmp({nm, ".ovf"},     {31'd0, ovf},    {31'd0, e.ovf});
    cmp({nm, ".cap_q"},   capq,          32'(e.capq));
    cmp({nm, ".cap_vld"}, {31'd0, capvld}, {31'd0, e.capvld});
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A", m[0], 32'(ifa.q), ifa.tc, ifa.ovf, 32'(ifa.cap_q), ifa.cap_vld);
      chk("B", m[1], 32'(ifb.q), ifb.tc, ifb.ovf, 32'(ifb.cap_q), ifb.cap_vld);
      chk("C", m[2], 32'(ifc.q), ifc.tc, ifc.ovf, 32'(ifc.cap_q), ifc.cap_vld);
      chk("D", m[3], 32'(ifd.q), ifd.tc, ifd.ovf, 32'(ifd.cap_q), ifd.cap_vld);
    end
  end

  // Advance n cycles; inputs change just after the falling edge
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    compared = 0; mismatched = 0; chk_en = 1'b0; rst_ = 1'b0;
    ifa.en = 0; ifa.up = 1; ifa.clr = 0; ifa.load = 0; ifa.din = '0; ifa.ovf_clr = 0; ifa.cap = 0;
    ifb.en = 0; ifb.up = 1; ifb.clr = 0; ifb.load = 0; ifb.din = '0; ifb.ovf_clr = 0; ifb.cap = 0;
    ifc.en = 0; ifc.up = 1; ifc.clr = 0; ifc.load = 0; ifc.din = '0; ifc.ovf_clr = 0; ifc.cap = 0;
    ifd.en = 0; ifd.up = 1; ifd.clr = 0; ifd.load = 0; ifd.din = '0; ifd.ovf_clr = 0; ifd.cap = 0;
    cyc(2);
    cmp("reset_q", 32'(ifa.q), 0);
    cmp("reset_ovf", {31'd0, ifa.ovf}, 0);
    rst_ = 1'b1; chk_en = 1'b1;

    // Up count on the modulo-10 instance and back-to-back wraps on modulo-2
    ifa.en = 1; ifd.en = 1;
    cyc(9);
    cmp("A_q_after9", 32'(ifa.q), 9);
    cyc(1);
    cmp("A_wrap_q", 32'(ifa.q), 0);
    cmp("A_wrap_tc", {31'd0, ifa.tc}, 1);
    cmp("D_q_after10", 32'(ifd.q), 0);
    cmp("D_tc_after10", {31'd0, ifd.tc}, 1);
    cyc(2);
    cmp("A_q_after12", 32'(ifa.q), 2);
    cmp("A_tc_after12", {31'd0, ifa.tc}, 0);
    cmp("A_ovf_sticky", {31'd0, ifa.ovf}, 1);
    ifa.en = 0; ifd.en = 0;

    // DIV=3 down count with enable gaps
    ifb.up = 0; ifb.en = 1;
    cyc(2);
    cmp("B_q_prescale", 32'(ifb.q), 0);
    cyc(1);
    cmp("B_q_wrap", 32'(ifb.q), 9);
    cmp("B_tc_wrap", {31'd0, ifb.tc}, 1);
    cyc(3);
    cmp("B_q_second", 32'(ifb.q), 8);
    cyc(1);
    ifb.en = 0; cyc(2);
    ifb.en = 1; cyc(1);
    cmp("B_q_gap", 32'(ifb.q), 8);
    cyc(1);
    cmp("B_q_after_gap", 32'(ifb.q), 7);

    // Load mid-prescale restarts the prescaler
    cyc(1);
    ifb.load = 1; ifb.din = 4'd5; cyc(1);
    ifb.load = 0;
    cmp("B_load", 32'(ifb.q), 5);
    cyc(2);
    cmp("B_load_hold", 32'(ifb.q), 5);
    cyc(1);
    cmp("B_load_step", 32'(ifb.q), 4);
    ifb.en = 0;

    // Saturating load, clear over load
    ifa.load = 1; ifa.din = 4'd13; cyc(1);
    cmp("A_load_sat", 32'(ifa.q), 9);
    ifa.din = 4'd5; ifa.clr = 1; cyc(1);
    cmp("A_clr_wins", 32'(ifa.q), 0);
    ifa.clr = 0;

    // Wrap with simultaneous ovf_clr keeps ovf set
    ifa.din = 4'd9; cyc(1);
    ifa.load = 0; ifa.ovf_clr = 1; cyc(1);
    cmp("A_ovf_cleared", {31'd0, ifa.ovf}, 0);
    ifa.en = 1; ifa.up = 1; cyc(1);
    cmp("A_wrap_q2", 32'(ifa.q), 0);
    cmp("A_wrap_tc2", {31'd0, ifa.tc}, 1);
    cmp("A_set_wins", {31'd0, ifa.ovf}, 1);
    ifa.en = 0; cyc(1);
    cmp("A_ovf_clr_alone", {31'd0, ifa.ovf}, 0);
    cmp("A_tc_drop", {31'd0, ifa.tc}, 0);
    ifa.ovf_clr = 0;

    // Full 16-bit range wrap both ways
    ifc.load = 1; ifc.din = 16'hFFFF; cyc(1);
    cmp("C_load_max", 32'(ifc.q), 65535);
    ifc.load = 0; ifc.en = 1; ifc.up = 1; cyc(1);
    cmp("C_up_wrap", 32'(ifc.q), 0);
    cmp("C_up_tc", {31'd0, ifc.tc}, 1);
    ifc.up = 0; cyc(1);
    cmp("C_down_wrap", 32'(ifc.q), 65535);
    cmp("C_down_tc", {31'd0, ifc.tc}, 1);
    ifc.en = 0; cyc(1);

    // Snapshot during a step
    ifa.load = 1; ifa.din = 4'd7; cyc(1);
    ifa.load = 0; ifa.en = 1; ifa.up = 1; ifa.cap = 1; cyc(1);
    cmp("A_cap_step_q", 32'(ifa.q), 8);
`ifdef PARAM_MOD_COUNTER_CAPTURE_EN
    cmp("A_cap_q", 32'(ifa.cap_q), 7);
    cmp("A_cap_vld", {31'd0, ifa.cap_vld}, 1);
`else
    cmp("A_cap_q", 32'(ifa.cap_q), 0);
    cmp("A_cap_vld", {31'd0, ifa.cap_vld}, 0);
`endif
    ifa.cap = 0; ifa.en = 0; cyc(1);
    cmp("A_cap_vld_drop", {31'd0, ifa.cap_vld}, 0);

    // Reset mid-count drops everything at once, prescale included
    ifa.en = 1; ifb.en = 1; ifb.up = 1; ifc.en = 1; ifd.en = 1;
    cyc(2);
    rst_ = 1'b0; #1;
    cmp("rst_A_q", 32'(ifa.q), 0);
    cmp("rst_A_ovf", {31'd0, ifa.ovf}, 0);
    cmp("rst_C_q", 32'(ifc.q), 0);
    cmp("rst_B_q", 32'(ifb.q), 0);
    cyc(1);
    rst_ = 1'b1;
    cyc(2);
    cmp("B_after_rst_hold", 32'(ifb.q), 0);
    cyc(1);
    cmp("B_after_rst_step", 32'(ifb.q), 1);
    cyc(5);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
